// File: rtl/flash_byte_reader_if.sv
// Avalon-MM pipelined read bus between flash_byte_reader (master) and the flash controller (slave).
interface flash_byte_reader_if #(
  parameter int unsigned ADDR_W = 21
);

  logic [ADDR_W-3:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    output avm_byteenable,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_byteenable,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/flash_byte_reader.sv
// Byte reader: turns a level-held byte-address request into one 32-bit Avalon
// word read, selects the addressed byte and pulses finish_read for one clk.
// Optional macro WORD_CACHE_EN adds a one-entry word cache that serves repeat
// reads of the same word without a bus access.
module flash_byte_reader #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [7:0]        data_out,
  output logic              finish_read,
  output logic              timeout_err,
  flash_byte_reader_if.master avm
);

  localparam int unsigned WADDR_W = ADDR_W - 2;
  localparam int unsigned CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    DONE,
    WAIT_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_sel_q, byte_sel_d;
  logic [WADDR_W-1:0] avm_addr_q, avm_addr_d;
  logic               avm_read_q, avm_read_d;
  logic [7:0]         data_q, data_d;
  logic               fin_q, fin_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef WORD_CACHE_EN
  logic [WADDR_W-1:0] tag_q, tag_d;
  logic [31:0]        cword_q, cword_d;
  logic               cvld_q, cvld_d;
  logic               hit_c;

  assign hit_c = cvld_q && (addr_in[ADDR_W-1:2] == tag_q);
`endif

  // Little-endian byte lane select.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] s);
    return w[{s, 3'b000} +: 8];
  endfunction

  assign data_out           = data_q;
  assign finish_read        = fin_q;
  assign timeout_err        = terr_q;
  assign avm.avm_address    = avm_addr_q;
  assign avm.avm_read       = avm_read_q;
  assign avm.avm_byteenable = 4'hF;

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state_q    <= IDLE;
      byte_sel_q <= 2'b00;
      avm_addr_q <= '0;
      avm_read_q <= 1'b0;
      data_q     <= 8'h00;
      fin_q      <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      avm_addr_q <= avm_addr_d;
      avm_read_q <= avm_read_d;
      data_q     <= data_d;
      fin_q      <= fin_d;
      terr_q     <= terr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef WORD_CACHE_EN
  // Word cache registers.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      tag_q   <= '0;
      cword_q <= 32'h0;
      cvld_q  <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      cword_q <= cword_d;
      cvld_q  <= cvld_d;
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    avm_addr_d = avm_addr_q;
    avm_read_d = avm_read_q;
    data_d     = data_q;
    terr_d     = terr_q;
    cnt_d      = cnt_q;
`ifdef WORD_CACHE_EN
    tag_d      = tag_q;
    cword_d    = cword_q;
    cvld_d     = cvld_q;
`endif

    case (state_q)
      IDLE: begin
        if (read_start) begin
          byte_sel_d = addr_in[1:0];
`ifdef WORD_CACHE_EN
          if (hit_c) begin
            data_d  = sel_byte(cword_q, addr_in[1:0]);
            state_d = DONE;
          end else begin
            avm_addr_d = addr_in[ADDR_W-1:2];
            avm_read_d = 1'b1;
            cnt_d      = '0;
            state_d    = REQ;
          end
`else
          avm_addr_d = addr_in[ADDR_W-1:2];
          avm_read_d = 1'b1;
          cnt_d      = '0;
          state_d    = REQ;
`endif
        end
      end

      REQ: begin
        if (cnt_q == CNT_LAST) begin
          avm_read_d = 1'b0;
          data_d     = 8'h00;
          terr_d     = 1'b1;
          state_d    = DONE;
`ifdef WORD_CACHE_EN
          cvld_d     = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!avm.avm_waitrequest) begin
            avm_read_d = 1'b0;
            state_d    = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        if (avm.avm_readdatavalid) begin
          data_d  = sel_byte(avm.avm_readdata, byte_sel_q);
          state_d = DONE;
`ifdef WORD_CACHE_EN
          tag_d   = avm_addr_q;
          cword_d = avm.avm_readdata;
          cvld_d  = 1'b1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          avm_read_d = 1'b0;
          data_d     = 8'h00;
          terr_d     = 1'b1;
          state_d    = DONE;
`ifdef WORD_CACHE_EN
          cvld_d     = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = read_start ? WAIT_RELEASE : IDLE;
      end

      WAIT_RELEASE: begin
        if (!read_start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    fin_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_flash_byte_reader.sv
// Directed bench for flash_byte_reader: single reads, stalls, held requests,
// timeout, mid-transfer reset and (with WORD_CACHE_EN) the word cache.
module tb_flash_byte_reader;

  logic        clk = 1'b0;
  logic        reset_all;
  logic        read_start;
  logic [20:0] addr_in;
  logic [7:0]  data_out;
  logic        finish_read;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_fin   = 0;
  int a0, f0, n;

  flash_byte_reader_if #(.ADDR_W(21)) avm_bus ();

  flash_byte_reader #(.ADDR_W(21), .TIMEOUT_CYC(255)) dut (
    .clk        (clk),
    .reset_all  (reset_all),
    .read_start (read_start),
    .addr_in    (addr_in),
    .data_out   (data_out),
    .finish_read(finish_read),
    .timeout_err(timeout_err),
    .avm        (avm_bus)
  );

  always #5 clk = ~clk;

  // Count accepted bus reads and finish pulses.
  always @(posedge clk) begin
    if (reset_all && avm_bus.avm_read && !avm_bus.avm_waitrequest) n_acc <= n_acc + 1;
    if (finish_read) n_fin <= n_fin + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request with no stall; readdatavalid held so data returns on the first WAIT_DATA edge.
  task automatic run_read(input logic [20:0] a, input logic [31:0] rd, input logic [7:0] exp,
                          input string tag, output int cyc);
    read_start = 1'b1;
    addr_in    = a;
    avm_bus.avm_readdata      = rd;
    avm_bus.avm_readdatavalid = 1'b1;
    avm_bus.avm_waitrequest   = 1'b0;
    cyc = 0;
    while (finish_read !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, "_fin"}, 32'(finish_read), 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(exp));
    avm_bus.avm_readdatavalid = 1'b0;
    read_start = 1'b0;
    tick();
  endtask

  initial begin
    reset_all  = 1'b0;
    read_start = 1'b0;
    addr_in    = '0;
    avm_bus.avm_waitrequest   = 1'b0;
    avm_bus.avm_readdata      = 32'h0;
    avm_bus.avm_readdatavalid = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_fin", 32'(finish_read), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    check("rst_read", 32'(avm_bus.avm_read), 32'h0);
    check("rst_addr", 32'(avm_bus.avm_address), 32'h0);
    check("byteenable", 32'(avm_bus.avm_byteenable), 32'hF);
    reset_all = 1'b1;
    tick();

    // T1: addr 5, data two cycles after accept -> byte 1 = CC
    a0 = n_acc; f0 = n_fin;
    read_start = 1'b1; addr_in = 21'h000005;
    tick();
    check("t1_read_hi", 32'(avm_bus.avm_read), 32'd1);
    check("t1_addr", 32'(avm_bus.avm_address), 32'h00001);
    tick();
    check("t1_read_lo", 32'(avm_bus.avm_read), 32'd0);
    tick();
    check("t1_no_fin", 32'(finish_read), 32'd0);
    avm_bus.avm_readdata = 32'hAABBCCDD; avm_bus.avm_readdatavalid = 1'b1;
    tick();
    check("t1_fin", 32'(finish_read), 32'd1);
    check("t1_data", 32'(data_out), 32'hCC);
    avm_bus.avm_readdatavalid = 1'b0; read_start = 1'b0;
    tick();
    check("t1_fin_once", 32'(finish_read), 32'd0);
    check("t1_acc", 32'(n_acc - a0), 32'd1);
    check("t1_fincnt", 32'(n_fin - f0), 32'd1);

    // T2: waitrequest stall, addr change and read_start drop mid-transfer
    a0 = n_acc; f0 = n_fin;
    read_start = 1'b1; addr_in = 21'h000102; avm_bus.avm_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t2_read_stable", 32'(avm_bus.avm_read), 32'd1);
      check("t2_addr_stable", 32'(avm_bus.avm_address), 32'h00040);
      if (i == 1) addr_in = 21'h1FFFFF;
      if (i == 2) read_start = 1'b0;
    end
    avm_bus.avm_waitrequest = 1'b0;
    tick();
    check("t2_read_lo", 32'(avm_bus.avm_read), 32'd0);
    avm_bus.avm_readdata = 32'h55667788; avm_bus.avm_readdatavalid = 1'b1;
    tick();
    check("t2_fin", 32'(finish_read), 32'd1);
    check("t2_data", 32'(data_out), 32'h66);
    avm_bus.avm_readdatavalid = 1'b0;
    tick();
    check("t2_fin_once", 32'(finish_read), 32'd0);
    check("t2_acc", 32'(n_acc - a0), 32'd1);
    check("t2_fincnt", 32'(n_fin - f0), 32'd1);

    // T3: request held 20 cycles after completion, then re-armed
    a0 = n_acc; f0 = n_fin;
    read_start = 1'b1; addr_in = 21'h000208; avm_bus.avm_readdata = 32'h0A0B0C0D;
    tick(); tick();
    avm_bus.avm_readdatavalid = 1'b1;
    tick();
    check("t3_fin", 32'(finish_read), 32'd1);
    check("t3_data", 32'(data_out), 32'h0D);
    avm_bus.avm_readdatavalid = 1'b0;
    repeat (20) tick();
    check("t3_hold_read", 32'(avm_bus.avm_read), 32'd0);
    check("t3_hold_acc", 32'(n_acc - a0), 32'd1);
    check("t3_hold_fin", 32'(n_fin - f0), 32'd1);
    read_start = 1'b0;
    tick();
    read_start = 1'b1; addr_in = 21'h00030F; avm_bus.avm_readdata = 32'hDEADBEEF;
    tick();
    check("t3_rearm_read", 32'(avm_bus.avm_read), 32'd1);
    check("t3_rearm_addr", 32'(avm_bus.avm_address), 32'h000C3);
    tick();
    avm_bus.avm_readdatavalid = 1'b1;
    tick();
    check("t3_rearm_fin", 32'(finish_read), 32'd1);
    check("t3_rearm_data", 32'(data_out), 32'hDE);
    avm_bus.avm_readdatavalid = 1'b0; read_start = 1'b0;
    tick();
    check("t3_acc", 32'(n_acc - a0), 32'd2);

    // T4: no readdatavalid -> timeout 255 cycles after REQ entry
    check("t4_terr_pre", 32'(timeout_err), 32'd0);
    a0 = n_acc;
    read_start = 1'b1; addr_in = 21'h00040C;
    n = 0;
    while (finish_read !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("t4_latency", 32'(n), 32'd256);
    check("t4_data", 32'(data_out), 32'h00);
    check("t4_terr", 32'(timeout_err), 32'd1);
    check("t4_read", 32'(avm_bus.avm_read), 32'd0);
    check("t4_acc", 32'(n_acc - a0), 32'd1);
    read_start = 1'b0;
    tick();
    check("t4_fin_once", 32'(finish_read), 32'd0);
    run_read(21'h000510, 32'h12345678, 8'h78, "t4_after", n);
    check("t4_after_lat", 32'(n), 32'd3);
    check("t4_terr_sticky", 32'(timeout_err), 32'd1);

    // T5: reset in WAIT_DATA, late readdatavalid ignored
    read_start = 1'b1; addr_in = 21'h000624;
    tick(); tick();
    read_start = 1'b0;
    reset_all = 1'b0;
    #1;
    check("t5_rst_data", 32'(data_out), 32'h0);
    check("t5_rst_terr", 32'(timeout_err), 32'h0);
    check("t5_rst_read", 32'(avm_bus.avm_read), 32'h0);
    check("t5_rst_addr", 32'(avm_bus.avm_address), 32'h0);
    tick();
    reset_all = 1'b1;
    avm_bus.avm_readdata = 32'hFFFFFFFF; avm_bus.avm_readdatavalid = 1'b1;
    tick();
    check("t5_late_fin", 32'(finish_read), 32'd0);
    check("t5_late_data", 32'(data_out), 32'h0);
    tick();
    check("t5_late_fin2", 32'(finish_read), 32'd0);
    avm_bus.avm_readdatavalid = 1'b0;
    run_read(21'h000731, 32'h1234AB00, 8'hAB, "t5_next", n);
    check("t5_next_lat", 32'(n), 32'd3);
    check("t5_next_terr", 32'(timeout_err), 32'd0);

    // T6: two bytes of one word
    run_read(21'h000004, 32'h11223344, 8'h44, "t6_first", n);
    check("t6_first_lat", 32'(n), 32'd3);
    a0 = n_acc;
    run_read(21'h000005, 32'h11223344, 8'h33, "t6_second", n);
`ifdef WORD_CACHE_EN
    check("t6_hit_lat", 32'(n), 32'd1);
    check("t6_hit_acc", 32'(n_acc - a0), 32'd0);
`else
    check("t6_miss_lat", 32'(n), 32'd3);
    check("t6_miss_acc", 32'(n_acc - a0), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
